avalon_input_pio_irq: RTL and testbench

Parametrised successor to the team's read-only Avalon-MM input PIO, used for switch and key banks on the HPS lightweight bridge.
- Inputs pass through a configurable synchronizer and per-bit debouncer.
- Configurable edges are latched into a sticky edge-capture register.
- A masked, level-sensitive interrupt goes to the HPS.
- Register map matches the standard PIO layout, so existing software drivers work unchanged.

---
 rtl/avalon_pio_pkg.sv | 41 ++++
 rtl/pio_bit_conditioner.sv | 79 +++++++
 rtl/avalon_input_pio_irq.sv | 142 ++++++++++++++
 tb/tb_avalon_input_pio_irq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the Avalon-MM input PIO: register map, edge
// selection encodings and small elaboration-time helpers.
package avalon_pio_pkg;

  // Word addresses of the standard PIO register layout.
  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_DIR      = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } reg_addr_e;

  // Which transition of the debounced input sets the capture bit.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int BUS_WIDTH = 32;

  // Width of a debounce counter able to hold the value 'cycles'.
  // Never returns less than 1 so a bypassed debouncer still elaborates.
  function automatic int debounce_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  // Bus-wide mask with the low 'width' bits set; used to keep unused
  // register bits at zero for any WIDTH up to the full bus.
  function automatic logic [BUS_WIDTH-1:0] width_mask(input int width);
    logic [BUS_WIDTH-1:0] m;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      m[i] = (i < width) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/pio_bit_conditioner.sv
// Per-bit input conditioning: multi-flop synchronizer followed by an
// optional consecutive-cycle debouncer. 'stable' is the accepted level.
module pio_bit_conditioner
  import avalon_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;

  // Synchronizer shift chain; din enters at bit 0, sync_q leaves at the top.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass

      // No debouncing: the stable level is the synchronized input, registered.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          stable <= 1'b0;
        end else begin
          stable <= sync_q;
        end
      end

    end else begin : g_debounce

      localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_next;
      logic             stable_next;

      // Count cycles of disagreement; accept the new level once the count
      // has reached the limit and the input still disagrees.
      always_comb begin
        cnt_next    = cnt;
        stable_next = stable;
        if (sync_q == stable) begin
          cnt_next = {CNT_W{1'b0}};
        end else if (cnt == CNT_LIMIT) begin
          stable_next = sync_q;
          cnt_next    = {CNT_W{1'b0}};
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      // Debounce counter and accepted level.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt    <= {CNT_W{1'b0}};
          stable <= 1'b0;
        end else begin
          cnt    <= cnt_next;
          stable <= stable_next;
        end
      end

    end
  endgenerate

endmodule

// File: rtl/avalon_input_pio_irq.sv
// Read-only Avalon-MM input PIO with synchronizer/debouncer per bit,
// sticky edge capture (write-1-to-clear) and a masked level interrupt.
module avalon_input_pio_irq
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH           = 21,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [BUS_WIDTH-1:0] VALID_MASK = width_mask(WIDTH);

  logic [WIDTH-1:0]     stable;
  logic [WIDTH-1:0]     prev;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     fall;
  logic [WIDTH-1:0]     edge_hit;
  logic                 sel_rise;
  logic                 sel_fall;

  logic [BUS_WIDTH-1:0] data_word;
  logic [BUS_WIDTH-1:0] edge_word;
  logic [BUS_WIDTH-1:0] wr_bits;
  logic [BUS_WIDTH-1:0] clr_bits;
  logic [BUS_WIDTH-1:0] mask_next;
  logic [BUS_WIDTH-1:0] cap_next;
  logic [BUS_WIDTH-1:0] read_mux;
  logic [BUS_WIDTH-1:0] irq_mask;
  logic [BUS_WIDTH-1:0] edge_capture;
  logic                 bus_write;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_bit_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[gi]),
        .stable (stable[gi])
      );
    end
  endgenerate

  // Previous stable value for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev <= {WIDTH{1'b0}};
    end else begin
      prev <= stable;
    end
  end

  // Edge detection and selection of which transitions count.
  always_comb begin
    rise = stable & ~prev;
    fall = ~stable & prev;
    case (EDGE_TYPE)
      EDGE_RISING: begin
        sel_rise = 1'b1;
        sel_fall = 1'b0;
      end
      EDGE_FALLING: begin
        sel_rise = 1'b0;
        sel_fall = 1'b1;
      end
      EDGE_ANY: begin
        sel_rise = 1'b1;
        sel_fall = 1'b1;
      end
      default: begin
        sel_rise = 1'b1;
        sel_fall = 1'b0;
      end
    endcase
    edge_hit = (rise & {WIDTH{sel_rise}}) | (fall & {WIDTH{sel_fall}});
  end

  // Bus decode and next values of the mask and capture registers. A new
  // edge is OR-ed in after the clear so a same-cycle set wins.
  always_comb begin
    data_word                = {BUS_WIDTH{1'b0}};
    data_word[WIDTH-1:0]     = stable;
    edge_word                = {BUS_WIDTH{1'b0}};
    edge_word[WIDTH-1:0]     = edge_hit;
    wr_bits                  = writedata & VALID_MASK;
    bus_write                = chipselect & ~write_n;
    if (bus_write && (address == ADDR_IRQ_MASK)) begin
      mask_next = wr_bits;
    end else begin
      mask_next = irq_mask;
    end
    if (bus_write && (address == ADDR_EDGE_CAP)) begin
      clr_bits = wr_bits;
    end else begin
      clr_bits = {BUS_WIDTH{1'b0}};
    end
    cap_next = (edge_capture & ~clr_bits) | edge_word;
  end

  // Read multiplexer; sampled every cycle regardless of chipselect.
  always_comb begin
    case (reg_addr_e'(address))
      ADDR_DATA:     read_mux = data_word;
      ADDR_DIR:      read_mux = {BUS_WIDTH{1'b0}};
      ADDR_IRQ_MASK: read_mux = irq_mask;
      ADDR_EDGE_CAP: read_mux = edge_capture;
      default:       read_mux = {BUS_WIDTH{1'b0}};
    endcase
  end

  // Mask, capture and registered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask     <= {BUS_WIDTH{1'b0}};
      edge_capture <= {BUS_WIDTH{1'b0}};
      readdata     <= {BUS_WIDTH{1'b0}};
    end else begin
      irq_mask     <= mask_next;
      edge_capture <= cap_next;
      readdata     <= read_mux;
    end
  end

  // Level interrupt straight from the registers so it follows them with
  // no extra delay.
  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_avalon_input_pio_irq.sv
// Randomised plus directed bench for avalon_input_pio_irq. Two instances
// share the bus and inputs: one undebounced/rising-edge, one debounced
// (10 cycles)/any-edge. A behavioural model predicts both.
module tb_avalon_input_pio_irq;

  localparam int W    = 21;
  localparam int SYNC = 2;
  localparam int NI   = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd0, rd1;
  logic          irq0, irq1;
  logic          chk_on = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  avalon_input_pio_irq #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  avalon_input_pio_irq #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(10), .EDGE_TYPE(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // in_port is seen SYNC cycles late; a bit is accepted once it has
  // disagreed with the accepted level for (debounce+1) consecutive samples.
  logic [W-1:0]  m_pipe   [NI][SYNC];
  logic [W-1:0]  m_stable [NI];
  logic [W-1:0]  m_prev   [NI];
  int            m_run    [NI][W];
  logic [31:0]   m_mask   [NI];
  logic [31:0]   m_cap    [NI];
  logic [31:0]   m_rd     [NI];

  task automatic model_step(input int k);
    logic [W-1:0] synced, ev;
    logic [31:0]  clr;
    int           dc;
    dc = (k == 0) ? 0 : 10;
    if (!reset_n) begin
      for (int s = 0; s < SYNC; s++) m_pipe[k][s] = '0;
      for (int i = 0; i < W; i++) m_run[k][i] = 0;
      m_stable[k] = '0; m_prev[k] = '0;
      m_mask[k] = 32'd0; m_cap[k] = 32'd0; m_rd[k] = 32'd0;
    end else begin
      if (k == 0) ev = m_stable[k] & ~m_prev[k];
      else        ev = m_stable[k] ^ m_prev[k];
      case (address)
        2'd0:    m_rd[k] = {11'd0, m_stable[k]};
        2'd1:    m_rd[k] = 32'd0;
        2'd2:    m_rd[k] = m_mask[k];
        default: m_rd[k] = m_cap[k];
      endcase
      clr = 32'd0;
      if (chipselect && !write_n) begin
        if (address == 2'd2) m_mask[k] = {11'd0, writedata[W-1:0]};
        if (address == 2'd3) clr = writedata;
      end
      m_cap[k]  = (m_cap[k] & ~clr) | {11'd0, ev};
      m_prev[k] = m_stable[k];
      synced = m_pipe[k][0];
      for (int i = 0; i < W; i++) begin
        if (synced[i] != m_stable[k][i]) begin
          if (m_run[k][i] == dc) begin
            m_stable[k][i] = synced[i];
            m_run[k][i] = 0;
          end else begin
            m_run[k][i]++;
          end
        end else begin
          m_run[k][i] = 0;
        end
      end
      for (int s = 0; s < SYNC - 1; s++) m_pipe[k][s] = m_pipe[k][s+1];
      m_pipe[k][SYNC-1] = in_port;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
  end

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("model_rd0",  rd0, m_rd[0]);
      check_eq("model_irq0", {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
      check_eq("model_rd1",  rd1, m_rd[1]);
      check_eq("model_irq1", {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0; in_port = 21'h0A5A5A;
    cyc(1);
    chk_on = 1'b1;
    check_eq("reset_rd", rd0, 32'd0);
    check_eq("reset_irq", {31'd0, irq0}, 32'd0);
    cyc(1);
    reset_n = 1'b1;

    // DATA read after the synchronizer has filled.
    cyc(5);
    check_eq("data_read", rd0, 32'h000A5A5A);
    address = 2'd1;
    cyc(1);
    check_eq("dir_read", rd0, 32'd0);
    wr(2'd0, 32'hFFFFFFFF);
    address = 2'd0;
    cyc(1);
    check_eq("data_ro", rd0, 32'h000A5A5A);

    // A write strobe without chipselect leaves the mask alone.
    address = 2'd2; writedata = 32'hFFFFFFFF; write_n = 1'b0;
    cyc(1);
    write_n = 1'b1;
    cyc(1);
    check_eq("mask_nocs", rd0, 32'd0);

    // Edge on bit 0 with mask bit 0 set.
    in_port = 21'h0;
    cyc(20);
    wr(2'd3, 32'hFFFFFFFF);
    wr(2'd2, 32'h1);
    in_port = 21'h1; address = 2'd3;
    cyc(4);
    check_eq("edge_irq", {31'd0, irq0}, 32'd1);
    cyc(1);
    check_eq("edge_cap", rd0, 32'h1);
    wr(2'd3, 32'h1);
    check_eq("w1c_irq", {31'd0, irq0}, 32'd0);

    // Capture without mask, then enable the mask.
    wr(2'd2, 32'h0);
    in_port = 21'h9;
    cyc(6);
    address = 2'd3;
    cyc(1);
    check_eq("mask_cap", rd0, 32'h8);
    check_eq("mask_irq0", {31'd0, irq0}, 32'd0);
    wr(2'd2, 32'h8);
    check_eq("mask_irq1", {31'd0, irq0}, 32'd1);

    // Debounce on the 10-cycle instance: 9-cycle glitch rejected.
    cyc(20);
    wr(2'd3, 32'hFFFFFFFF);
    address = 2'd0;
    in_port = 21'hD;
    cyc(9);
    in_port = 21'h9;
    cyc(25);
    check_eq("glitch_data", rd1, 32'h9);
    address = 2'd3;
    cyc(1);
    check_eq("glitch_cap", rd1, 32'h0);
    in_port = 21'hD;
    cyc(16);
    check_eq("deb_cap", rd1, 32'h4);
    address = 2'd0;
    cyc(1);
    check_eq("deb_data", rd1, 32'hD);

    // Clear of bit 0 in the same cycle a new rising edge arrives.
    in_port = 21'hC;
    cyc(6);
    wr(2'd3, 32'hFFFFFFFF);
    address = 2'd3;
    in_port = 21'hD;
    cyc(3);
    wr(2'd3, 32'h1);
    cyc(1);
    check_eq("set_wins", rd0 & 32'h1, 32'h1);

    // Reset while the interrupt is active.
    wr(2'd3, 32'hFFFFFFFF);
    wr(2'd2, 32'h10);
    in_port = 21'h1D; address = 2'd3;
    cyc(6);
    check_eq("pre_rst_irq", {31'd0, irq0}, 32'd1);
    check_eq("pre_rst_cap", rd0, 32'h10);
    reset_n = 1'b0; address = 2'd2;
    cyc(1);
    check_eq("rst_irq", {31'd0, irq0}, 32'd0);
    check_eq("rst_rd", rd0, 32'd0);
    reset_n = 1'b1;
    cyc(1);
    check_eq("rst_mask", rd0, 32'd0);
    address = 2'd3;
    cyc(1);
    check_eq("rst_cap", rd0, 32'd0);

    // Random traffic against the model.
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) in_port = in_port ^ (21'd1 << $urandom_range(0, 20));
      if ($urandom_range(0, 15) == 0) in_port = in_port ^ (21'd1 << $urandom_range(0, 3));
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 9) < 4);
      write_n    = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      reset_n    = ($urandom_range(0, 499) != 0);
      cyc(1);
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
